apb_mem_arbiter: RTL and testbench
==================================

// Module: apb_mem_arbiter
// PURPOSE
//  Shares one APB memory slave between the core's instruction and data APB master ports.
//  - Sits between core (imem_apb/dmem_apb masters) and a single unified apb_slave.
//  - Enables a von-Neumann memory build without changing the core.
//  - Serialises transfers, inserts one setup cycle per transfer and guards each transfer with a watchdog.
// PARAMETERS
//  TIMEOUT_CYCLES  64  downstream ACCESS cycles allowed before forced error completion; 0 disables the watchdog
// PORTS
//  clk          input   1       clock, all logic on rising edge
//  rst          input   1       synchronous reset, active-high
//  imem_apb     apb_if.slave  -  upstream port, connected to core instruction master
//  dmem_apb     apb_if.slave  -  upstream port, connected to core data master
//  mem_apb      apb_if.master -  downstream port, connected to shared memory
//  busy         output  1       FSM not in IDLE
//  grant        output  1       0=imem, 1=dmem; owner of current/last transfer
//  timeout_err  output  1       one-cycle pulse when the watchdog forces a completion
//  Port signals on every apb_if: psel, penable, pwrite, paddr[31:0], pwdata[31:0], prdata[31:0], pready, pslverr.
// BEHAVIOUR
//  Reset (sampled at clk edge while rst=1):
//   - state=IDLE, grant=0.
//   - mem psel/penable/pwrite/paddr/pwdata=0.
//   - busy=0, timeout_err=0.
//   - Both upstream pready=0, pslverr=0.
//   - Reset mid-transfer abandons the transfer: downstream psel drops at that edge and the upstream never sees pready.
//  Request: an upstream port requests when its psel=1. penable is ignored for arbitration.
//  FSM states:
//   - IDLE: on any request, choose a winner, latch its pwrite/paddr/pwdata into regs, set grant, go to SETUP. Otherwise stay.
//   - SETUP: mem psel=1, penable=0, driven from the latched regs. Go to ACCESS next cycle.
//   - ACCESS: mem psel=1, penable=1. If mem pready=1 or the watchdog expires, go to IDLE.
//  Completion (combinational in ACCESS, granted port only):
//   - Granted upstream pready = mem pready | wd_expire.
//   - prdata = mem prdata.
//   - pslverr = mem pslverr | wd_expire.
//   - Non-granted port always sees pready=0. prdata is 0 whenever pready=0.
//  Latency: upstream setup at cycle T gives mem SETUP at T+1, mem ACCESS at T+2, upstream completes at T+2+memwait. This is one wait state over direct connection.
//  Back-to-back: after completion the FSM is in IDLE for exactly one cycle; the next grant occurs there. No pipelining.
//  Simultaneous requests in IDLE: priority rule per CONFIGURATION.
//  A loser keeps psel high, per APB; it is served on the next IDLE.
//  Watchdog (TIMEOUT_CYCLES>0):
//   - Counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
//   - wd_expire=1 when count==TIMEOUT_CYCLES-1 and pready=0.
//   - timeout_err pulses in that cycle.
//   - Counter width = $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
//  Upstream changes of paddr/pwdata while waiting are ignored; the latched values are used.
// CONFIGURATION
//  Macro ARB_ROUND_ROBIN_EN:
//   - Defined: on a tie, grant the port NOT equal to grant (last winner). Since grant resets to 0, the first tie goes to dmem.
//   - Undefined: fixed priority, dmem always wins ties; imem can starve under continuous dmem traffic.
//  A single request is granted immediately in either mode.
// STRUCTURE
//  typedefs package additions:
//   - arb_state_t enum logic [1:0] {ARB_IDLE, ARB_SETUP, ARB_ACCESS}.
//   - arb_gnt_t enum logic {GNT_IMEM, GNT_DMEM}.
//  Sub-module apb_arb_watchdog (clk, rst, start, run, done, expire; param TIMEOUT_CYCLES): holds the counter and saturation logic.
//  Top level holds the FSM, grant selection, request latch and response muxing.
// TESTING
//  1) Lone imem read of addr 0x10 (mem 0-wait, data 0xDEADBEEF) -> imem pready high on 2nd cycle after setup, prdata=0xDEADBEEF, grant=0.
//  2) imem and dmem psel same cycle, dmem write 0x55 @0x100 -> dmem served first in both modes; imem completes 3 cycles after dmem.
//  3) RR build, both held requesting for 4 transfers -> grant sequence 1,0,1,0. Non-RR build -> 1,1,1,1 while dmem keeps requesting.
//  4) Mem pready held 0, TIMEOUT_CYCLES=4 -> 4th ACCESS cycle: upstream pready=1, pslverr=1, timeout_err pulse. Next transfer succeeds normally.
//  5) rst asserted during ACCESS -> next cycle mem psel=0, busy=0, no upstream pready. A request held through reset is re-granted after rst drops.
//  6) dmem changes paddr mid-wait, mem 3 wait states -> mem paddr stable at the latched value throughout SETUP/ACCESS.

Source files
------------

// File: rtl/apb_mem_arbiter_pkg.sv
// Shared types for the APB memory arbiter.
// Contents: FSM state enum, grant enum, bus widths and the tie-break helper used by the
// top-level grant selection.
package apb_mem_arbiter_pkg;

  localparam int unsigned APB_AW = 32;
  localparam int unsigned APB_DW = 32;

  typedef enum logic [1:0] {ARB_IDLE, ARB_SETUP, ARB_ACCESS} arb_state_t;

  typedef enum logic {GNT_IMEM, GNT_DMEM} arb_gnt_t;

  // Picks the winner among the current requesters. A lone request always wins. On a tie,
  // round-robin hands the bus to the port that did not win last time; otherwise dmem wins.
  function automatic arb_gnt_t arb_pick(input logic     req_imem,
                                        input logic     req_dmem,
                                        input arb_gnt_t last,
                                        input bit       rr_en);
    if (req_imem && req_dmem) begin
      if (rr_en) return (last == GNT_IMEM) ? GNT_DMEM : GNT_IMEM;
      return GNT_DMEM;
    end
    if (req_dmem) return GNT_DMEM;
    return GNT_IMEM;
  endfunction

endpackage

// File: rtl/apb_mem_arbiter_if.sv
// APB bus bundle used on all three arbiter ports.
// Signals: psel, penable, pwrite, paddr[31:0], pwdata[31:0] (master -> slave);
//          prdata[31:0], pready, pslverr (slave -> master).
// Modports: master (drives the request side), slave (drives the response side).
interface apb_if;
  import apb_mem_arbiter_pkg::*;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [APB_AW-1:0] paddr;
  logic [APB_DW-1:0] pwdata;
  logic [APB_DW-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_mem_arbiter_watchdog.sv
// Watchdog for one downstream APB transfer.
// Ports:
//   clk     clock, rising edge
//   rst     synchronous active-high reset
//   start   clears the counter (asserted the cycle before ACCESS)
//   run     downstream transfer is in ACCESS
//   done    downstream pready
//   expire  ACCESS has lasted TIMEOUT_CYCLES cycles without pready
// Parameter TIMEOUT_CYCLES: 0 removes the counter and expire stays low.
module apb_arb_watchdog
  import apb_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  input  logic done,
  output logic expire
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic w_unused_ok;
    assign w_unused_ok = ^{clk, rst, start, run, done};
    assign expire      = 1'b0;
  end else begin : g_on
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax  = '1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;

    // Saturating count of ACCESS cycles that ended without pready.
    always_comb begin
      w_cnt_d = r_cnt;
      if (start) begin
        w_cnt_d = '0;
      end else if (run && !done && (r_cnt != CntMax)) begin
        w_cnt_d = r_cnt + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) r_cnt <= '0;
      else     r_cnt <= w_cnt_d;
    end

    assign expire = run && !done && (r_cnt == CntLast);
  end

endmodule

// File: rtl/apb_mem_arbiter.sv
// Shares one APB memory slave between the core's instruction and data APB masters.
// Transfers are serialised: IDLE (grant + latch) -> SETUP -> ACCESS -> IDLE.
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   imem_apb     upstream APB slave port (core instruction master)
//   dmem_apb     upstream APB slave port (core data master)
//   mem_apb      downstream APB master port (shared memory)
//   busy         FSM not in IDLE
//   grant        0 = imem, 1 = dmem; owner of the current/last transfer
//   timeout_err  one-cycle pulse when the watchdog forces a completion
// Parameter TIMEOUT_CYCLES: ACCESS cycles allowed before forced error completion, 0 disables.
// Macro ARB_ROUND_ROBIN_EN: when defined, ties alternate between the ports; otherwise dmem
// always wins ties.
module apb_mem_arbiter
  import apb_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic  clk,
  input  logic  rst,
  apb_if.slave  imem_apb,
  apb_if.slave  dmem_apb,
  apb_if.master mem_apb,
  output logic  busy,
  output logic  grant,
  output logic  timeout_err
);

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  arb_state_t        r_state, w_state_d;
  arb_gnt_t          r_grant, w_grant_d;
  logic              r_pwrite, w_pwrite_d;
  logic [APB_AW-1:0] r_paddr, w_paddr_d;
  logic [APB_DW-1:0] r_pwdata, w_pwdata_d;

  logic     w_req_any;
  arb_gnt_t w_winner;
  logic     w_wd_expire;
  logic     w_in_access;
  logic     w_complete;
  logic     w_unused_ok;

  // Upstream penable plays no part in arbitration.
  assign w_unused_ok = imem_apb.penable ^ dmem_apb.penable;

  assign w_req_any = imem_apb.psel | dmem_apb.psel;
  assign w_winner  = arb_pick(imem_apb.psel, dmem_apb.psel, r_grant, RrEn);

  // State register plus the request latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ARB_IDLE;
      r_grant  <= GNT_IMEM;
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else begin
      r_state  <= w_state_d;
      r_grant  <= w_grant_d;
      r_pwrite <= w_pwrite_d;
      r_paddr  <= w_paddr_d;
      r_pwdata <= w_pwdata_d;
    end
  end

  // Next-state: the winner's request is captured only in IDLE, so later upstream changes are
  // invisible to the downstream transfer.
  always_comb begin
    w_state_d  = r_state;
    w_grant_d  = r_grant;
    w_pwrite_d = r_pwrite;
    w_paddr_d  = r_paddr;
    w_pwdata_d = r_pwdata;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_req_any) begin
          w_state_d = ARB_SETUP;
          w_grant_d = w_winner;
          if (w_winner == GNT_DMEM) begin
            w_pwrite_d = dmem_apb.pwrite;
            w_paddr_d  = dmem_apb.paddr;
            w_pwdata_d = dmem_apb.pwdata;
          end else begin
            w_pwrite_d = imem_apb.pwrite;
            w_paddr_d  = imem_apb.paddr;
            w_pwdata_d = imem_apb.pwdata;
          end
        end
      end
      ARB_SETUP:  w_state_d = ARB_ACCESS;
      ARB_ACCESS: if (mem_apb.pready || w_wd_expire) w_state_d = ARB_IDLE;
      default:    w_state_d = ARB_IDLE;
    endcase
  end

  assign w_in_access = (r_state == ARB_ACCESS);
  assign w_complete  = w_in_access && (mem_apb.pready || w_wd_expire);

  // Outputs: downstream request from the latch, responses routed to the granted port only.
  always_comb begin
    mem_apb.psel    = (r_state != ARB_IDLE);
    mem_apb.penable = w_in_access;
    mem_apb.pwrite  = r_pwrite;
    mem_apb.paddr   = r_paddr;
    mem_apb.pwdata  = r_pwdata;

    imem_apb.pready  = w_complete && (r_grant == GNT_IMEM);
    imem_apb.pslverr = w_in_access && (r_grant == GNT_IMEM) && (mem_apb.pslverr || w_wd_expire);
    imem_apb.prdata  = imem_apb.pready ? mem_apb.prdata : '0;

    dmem_apb.pready  = w_complete && (r_grant == GNT_DMEM);
    dmem_apb.pslverr = w_in_access && (r_grant == GNT_DMEM) && (mem_apb.pslverr || w_wd_expire);
    dmem_apb.prdata  = dmem_apb.pready ? mem_apb.prdata : '0;

    busy        = (r_state != ARB_IDLE);
    grant       = r_grant;
    timeout_err = w_wd_expire;
  end

  apb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .start (r_state == ARB_SETUP),
    .run   (w_in_access),
    .done  (mem_apb.pready),
    .expire(w_wd_expire)
  );

endmodule

// File: tb/tb_apb_mem_arbiter.sv
// Bench for apb_mem_arbiter: a behavioural memory slave with address-dependent wait states,
// two upstream masters driven from queued transactions, and a transaction-level model that
// predicts service order, completion cycle, read data and error for every transfer.
module tb_apb_mem_arbiter;

  localparam int unsigned TO = 4;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    int          done;
    logic [31:0] rdata;
    bit          err;
    bit          gnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy, grant, timeout_err;

  always #5 clk = ~clk;

  apb_if imem_if ();
  apb_if dmem_if ();
  apb_if mem_if ();

  apb_mem_arbiter #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_apb   (imem_if),
    .dmem_apb   (dmem_if),
    .mem_apb    (mem_if),
    .busy       (busy),
    .grant      (grant),
    .timeout_err(timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  bit          hang = 1'b0;
  int          acc_cnt = 0;
  logic [31:0] setup_addr = '0;

  txn_t tq [2][$];
  exp_t eq [2][$];
  bit   model_last = 1'b0;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a * 3 + 32'h1234;
  endfunction

  function automatic int wst(input logic [31:0] a);
    return int'(a[3:2]);
  endfunction

  // Memory slave: pready after wst(addr) wait states unless hung; writes land on completion.
  always @(posedge clk) begin
    if (mem_if.psel && !mem_if.penable) setup_addr = mem_if.paddr;
    if (mem_if.psel && mem_if.penable) begin
      check("mem_paddr_stable", mem_if.paddr, setup_addr);
      if (mem_if.pready) begin
        if (mem_if.pwrite) slv_mem[mem_if.paddr] = mem_if.pwdata;
        acc_cnt = 0;
      end else begin
        acc_cnt++;
      end
    end else begin
      acc_cnt = 0;
    end
    #1;
    mem_if.pslverr = 1'b0;
    if (mem_if.psel && mem_if.penable && !hang && acc_cnt >= wst(mem_if.paddr)) begin
      mem_if.pready = 1'b1;
      if (mem_if.pwrite) mem_if.prdata = '0;
      else mem_if.prdata = slv_mem.exists(mem_if.paddr) ? slv_mem[mem_if.paddr]
                                                       : dflt(mem_if.paddr);
    end else begin
      mem_if.pready = 1'b0;
      mem_if.prdata = '0;
    end
  end

  task automatic drive(input int p, input bit sel, input bit en, input txn_t t);
    if (p == 0) begin
      imem_if.psel = sel; imem_if.penable = en; imem_if.pwrite = t.wr;
      imem_if.paddr = t.addr; imem_if.pwdata = t.data;
    end else begin
      dmem_if.psel = sel; dmem_if.penable = en; dmem_if.pwrite = t.wr;
      dmem_if.paddr = t.addr; dmem_if.pwdata = t.data;
    end
  endtask

  function automatic logic [33:0] smp(input int p);
    if (p == 0) return {imem_if.pready, imem_if.pslverr, imem_if.prdata};
    return {dmem_if.pready, dmem_if.pslverr, dmem_if.prdata};
  endfunction

  // Transaction-level schedule: each transfer takes one IDLE slot, one SETUP cycle and its
  // ACCESS cycles; the next IDLE slot follows its completion.
  task automatic predict(input bit hg);
    int   idx [2];
    int   slot;
    int   p;
    int   acc;
    txn_t t;
    exp_t e;
    idx[0] = 0; idx[1] = 0; slot = 0;
    while (idx[0] < tq[0].size() || idx[1] < tq[1].size()) begin
      if (idx[0] < tq[0].size() && idx[1] < tq[1].size()) p = RR ? (model_last ? 0 : 1) : 1;
      else p = (idx[1] < tq[1].size()) ? 1 : 0;
      t = tq[p][idx[p]];
      idx[p]++;
      acc     = hg ? int'(TO) : wst(t.addr) + 1;
      e.done  = slot + 1 + acc;
      e.err   = hg;
      e.gnt   = p[0];
      e.rdata = (hg || t.wr) ? 32'h0 : (ref_mem.exists(t.addr) ? ref_mem[t.addr] : dflt(t.addr));
      if (t.wr && !hg) ref_mem[t.addr] = t.data;
      eq[p].push_back(e);
      model_last = p[0];
      slot = e.done + 1;
    end
  endtask

  task automatic run(input bit hg, input bit scr, input int budget);
    int          k;
    bit          act [2];
    bit          adv [2];
    bit          comp_now;
    logic [33:0] s;
    exp_t        e;
    txn_t        t;
    txn_t        idle_t;
    idle_t = '{wr: 1'b0, addr: 32'h0, data: 32'h0};
    hang = hg;
    predict(hg);
    k = 0;
    for (int p = 0; p < 2; p++) begin
      adv[p] = 1'b0;
      act[p] = (tq[p].size() > 0);
      if (act[p]) drive(p, 1'b1, 1'b0, tq[p][0]);
    end
    while ((act[0] || act[1]) && k < budget) begin
      @(negedge clk);
      k++;
      comp_now = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (adv[p]) begin
          adv[p] = 1'b0;
          void'(tq[p].pop_front());
          if (tq[p].size() > 0) drive(p, 1'b1, 1'b0, tq[p][0]);
          else begin
            drive(p, 1'b0, 1'b0, idle_t);
            act[p] = 1'b0;
          end
        end else if (act[p]) begin
          s = smp(p);
          if (s[33]) begin
            check("expected_completion", {31'b0, eq[p].size() != 0}, 32'd1);
            if (eq[p].size() != 0) begin
              e = eq[p].pop_front();
              check(p == 0 ? "imem_done_cycle" : "dmem_done_cycle", k, e.done);
              check(p == 0 ? "imem_prdata" : "dmem_prdata", s[31:0], e.rdata);
              check(p == 0 ? "imem_pslverr" : "dmem_pslverr", {31'b0, s[32]}, {31'b0, e.err});
              check("grant_at_completion", {31'b0, grant}, {31'b0, e.gnt});
            end
            comp_now = 1'b1;
            adv[p]   = 1'b1;
          end else begin
            check("prdata_zero_while_waiting", s[31:0], 32'h0);
            t = tq[p][0];
            if (scr) begin
              t.addr = $urandom;
              t.data = $urandom;
            end
            drive(p, 1'b1, 1'b1, t);
          end
        end else begin
          s = smp(p);
          check("idle_port_pready", {31'b0, s[33]}, 32'd0);
        end
      end
      check("timeout_err", {31'b0, timeout_err}, {31'b0, comp_now && hg});
    end
    check("run_within_budget", {31'b0, act[0] | act[1]}, 32'd0);
    check("busy_after_run", {31'b0, busy}, 32'd0);
    hang = 1'b0;
    tq[0].delete(); tq[1].delete(); eq[0].delete(); eq[1].delete();
  endtask

  function automatic txn_t rnd_txn();
    txn_t t;
    t.wr   = $urandom_range(0, 1) == 1;
    t.addr = 32'h100 + 32'($urandom_range(0, 15)) * 4;
    t.data = $urandom;
    return t;
  endfunction

  initial begin
    txn_t t;
    txn_t idle_t;
    int   k;
    logic [31:0] exp_rd;
    idle_t = '{wr: 1'b0, addr: 32'h0, data: 32'h0};
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, idle_t);
    drive(1, 1'b0, 1'b0, idle_t);
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_grant", {31'b0, grant}, 32'd0);
    check("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
    check("rst_mem_psel", {31'b0, mem_if.psel}, 32'd0);
    check("rst_mem_penable", {31'b0, mem_if.penable}, 32'd0);
    check("rst_mem_pwrite", {31'b0, mem_if.pwrite}, 32'd0);
    check("rst_mem_paddr", mem_if.paddr, 32'd0);
    check("rst_mem_pwdata", mem_if.pwdata, 32'd0);
    check("rst_imem_pready", {30'b0, imem_if.pready, imem_if.pslverr}, 32'd0);
    check("rst_dmem_pready", {30'b0, dmem_if.pready, dmem_if.pslverr}, 32'd0);
    rst = 1'b0;
    model_last = 1'b0;

    // Lone imem read, zero-wait memory.
    slv_mem[32'h10] = 32'hDEADBEEF;
    ref_mem[32'h10] = 32'hDEADBEEF;
    tq[0].push_back('{wr: 1'b0, addr: 32'h10, data: 32'h0});
    run(1'b0, 1'b0, 50);

    // Simultaneous requests: dmem write wins, imem follows three cycles later.
    tq[0].push_back('{wr: 1'b0, addr: 32'h10, data: 32'h0});
    tq[1].push_back('{wr: 1'b1, addr: 32'h100, data: 32'h55});
    run(1'b0, 1'b0, 50);
    check("mem_write_0x100", slv_mem[32'h100], 32'h55);

    // Both ports continuously requesting four transfers each.
    for (int i = 0; i < 4; i++) begin
      tq[0].push_back(rnd_txn());
      tq[1].push_back(rnd_txn());
    end
    run(1'b0, 1'b0, 200);

    // Hung memory: watchdog completes with error, then a normal transfer.
    tq[0].push_back('{wr: 1'b0, addr: 32'h104, data: 32'h0});
    run(1'b1, 1'b0, 50);
    tq[0].push_back('{wr: 1'b0, addr: 32'h104, data: 32'h0});
    run(1'b0, 1'b0, 50);

    // Reset during ACCESS abandons the transfer; the held request is served afterwards.
    hang = 1'b1;
    t = '{wr: 1'b0, addr: 32'h20, data: 32'h0};
    drive(1, 1'b1, 1'b0, t);
    @(negedge clk);
    drive(1, 1'b1, 1'b1, t);
    repeat (2) @(negedge clk);
    check("busy_in_access", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_mem_psel", {31'b0, mem_if.psel}, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_dmem_pready", {31'b0, dmem_if.pready}, 32'd0);
    check("rst_mid_grant", {31'b0, grant}, 32'd0);
    rst  = 1'b0;
    hang = 1'b0;
    model_last = 1'b0;
    k = 0;
    while (!dmem_if.pready && k < 20) begin
      @(negedge clk);
      k++;
    end
    exp_rd = ref_mem.exists(32'h20) ? ref_mem[32'h20] : dflt(32'h20);
    check("regrant_done_cycle", k, 2 + wst(32'h20));
    check("regrant_prdata", dmem_if.prdata, exp_rd);
    check("regrant_grant", {31'b0, grant}, 32'd1);
    model_last = 1'b1;
    @(negedge clk);
    drive(1, 1'b0, 1'b0, idle_t);

    // dmem scrambles paddr/pwdata while waiting on a three-wait-state address.
    tq[1].push_back('{wr: 1'b0, addr: 32'h10C, data: 32'h0});
    run(1'b0, 1'b1, 50);
    tq[1].push_back('{wr: 1'b1, addr: 32'h10C, data: 32'hA5A5_5A5A});
    run(1'b0, 1'b1, 50);
    check("mem_write_latched", slv_mem[32'h10C], 32'hA5A5_5A5A);

    // Random mixes.
    for (int r = 0; r < 8; r++) begin
      int ni, nd;
      ni = $urandom_range(0, 3);
      nd = $urandom_range(0, 3);
      if (ni == 0 && nd == 0) ni = 1;
      for (int i = 0; i < ni; i++) tq[0].push_back(rnd_txn());
      for (int i = 0; i < nd; i++) tq[1].push_back(rnd_txn());
      run(1'b0, 1'b0, 300);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
